// File: rtl/xosera_pkg.sv
// Shared definitions for the rectangle blitter: FSM states, XR register
// numbers and MODE bit positions.
package xosera_pkg;

    typedef enum logic [2:0] {
        BR_IDLE,
        BR_SETUP,
        BR_READ,
        BR_WAIT_READ,
        BR_WRITE,
        BR_WAIT_WRITE,
        BR_LINE_END,
        BR_DONE
    } blit_rect_state_t;

    localparam logic [3:0] XR_BLITR_MODE    = 4'h0;
    localparam logic [3:0] XR_BLITR_RD_MOD  = 4'h1;
    localparam logic [3:0] XR_BLITR_WR_MOD  = 4'h2;
    localparam logic [3:0] XR_BLITR_WR_MASK = 4'h3;
    localparam logic [3:0] XR_BLITR_WIDTH   = 4'h4;
    localparam logic [3:0] XR_BLITR_RD_ADDR = 4'h5;
    localparam logic [3:0] XR_BLITR_WR_ADDR = 4'h6;
    localparam logic [3:0] XR_BLITR_HEIGHT  = 4'h7;
    localparam logic [3:0] XR_BLITR_STATUS  = 4'hF;

    localparam int BLITR_MODE_FILL_BIT  = 15;
    localparam int BLITR_MODE_SHIFT_LSB = 0;
    localparam int BLITR_MODE_SHIFT_W   = 4;

endpackage

// File: rtl/blit_rect_shifter.sv
// Combinational nibble shifter with carry-in from the previous source word,
// plus first/last-word write-mask selection.
module blit_shifter #(
    parameter int DATA_W = 16,
    parameter int NIB_W  = DATA_W / 4
) (
    input  logic [DATA_W-1:0] carry_i,
    input  logic [DATA_W-1:0] cur_i,
    input  logic [3:0]        shift_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic [NIB_W-1:0]  first_mask_i,
    input  logic [NIB_W-1:0]  last_mask_i,
    output logic [DATA_W-1:0] data_o,
    output logic [NIB_W-1:0]  mask_o
);

    logic [2*DATA_W-1:0] cat;
    logic [2*DATA_W-1:0] shifted;

    always_comb begin
        cat     = {carry_i, cur_i};
        shifted = cat >> {shift_i, 2'b00};
        data_o  = shifted[DATA_W-1:0];

        if (first_i && last_i) begin
            mask_o = first_mask_i & last_mask_i;
        end else if (first_i) begin
            mask_o = first_mask_i;
        end else if (last_i) begin
            mask_o = last_mask_i;
        end else begin
            mask_o = '1;
        end
    end

endmodule

// File: rtl/blit_rect.sv
// 2-D VRAM rectangle copy/fill blitter on the XR register bus, with
// shadowed working registers and a one-deep request queue.
module blit_rect
    import xosera_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic                  xreg_wr_en_i,
    input  logic [3:0]            xreg_num_i,
    input  logic [DATA_W-1:0]     xreg_data_i,
    output logic [DATA_W-1:0]     xreg_data_o,
    output logic                  blit_busy_o,
    output logic                  blit_done_intr_o,
    output logic                  blit_vram_sel_o,
    input  logic                  blit_vram_ack_i,
    output logic                  blit_wr_o,
    output logic [DATA_W/4-1:0]   blit_wr_mask_o,
    output logic [ADDR_W-1:0]     blit_addr_o,
    input  logic [DATA_W-1:0]     blit_vram_data_i,
    output logic [DATA_W-1:0]     blit_data_o
);

    localparam int NIB_W = DATA_W / 4;

    typedef struct packed {
        logic                fill;
        logic [3:0]          shift;
        logic [ADDR_W-1:0]   rd_mod;
        logic [ADDR_W-1:0]   wr_mod;
        logic [NIB_W-1:0]    fmask;
        logic [NIB_W-1:0]    lmask;
        logic [CNT_W-1:0]    width;
        logic [DATA_W-1:0]   fill_val;
    } cfg_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   rd_addr;
        logic [ADDR_W-1:0]   wr_addr;
        logic [CNT_W-1:0]    col;
        logic [CNT_W-1:0]    row;
        logic [DATA_W-1:0]   carry;
        logic [DATA_W-1:0]   word;
    } ptr_t;

    typedef struct packed {
        logic                sel;
        logic                wr;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [NIB_W-1:0]    mask;
    } bus_t;

    // Reset is applied asynchronously but released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    logic [7:0][DATA_W-1:0] xr_q;
    logic [DATA_W-1:0]      r_mode, r_rd_mod, r_wr_mod, r_mask;
    logic [DATA_W-1:0]      r_width, r_rd_addr, r_wr_addr, r_height;
    logic [DATA_W-1:0]      rdata_q;

    assign r_mode    = xr_q[XR_BLITR_MODE[2:0]];
    assign r_rd_mod  = xr_q[XR_BLITR_RD_MOD[2:0]];
    assign r_wr_mod  = xr_q[XR_BLITR_WR_MOD[2:0]];
    assign r_mask    = xr_q[XR_BLITR_WR_MASK[2:0]];
    assign r_width   = xr_q[XR_BLITR_WIDTH[2:0]];
    assign r_rd_addr = xr_q[XR_BLITR_RD_ADDR[2:0]];
    assign r_wr_addr = xr_q[XR_BLITR_WR_ADDR[2:0]];
    assign r_height  = xr_q[XR_BLITR_HEIGHT[2:0]];

    blit_rect_state_t state_q, state_d;
    logic             queued_q, queued_d;
    cfg_t             cfg_q, cfg_d;
    ptr_t             ptr_q, ptr_d;
    bus_t             bus_q, bus_d;

    logic              busy;
    logic              height_wr;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] sh_data;
    logic [NIB_W-1:0]  sh_mask;

    assign busy      = (state_q != BR_IDLE);
    assign height_wr = xreg_wr_en_i && (xreg_num_i == XR_BLITR_HEIGHT);
    assign cur       = cfg_q.fill ? cfg_q.fill_val : ptr_q.word;

    blit_shifter #(
        .DATA_W(DATA_W),
        .NIB_W (NIB_W)
    ) u_shifter (
        .carry_i     (ptr_q.carry),
        .cur_i       (cur),
        .shift_i     (cfg_q.shift),
        .first_i     (ptr_q.col == cfg_q.width),
        .last_i      (ptr_q.col == '0),
        .first_mask_i(cfg_q.fmask),
        .last_mask_i (cfg_q.lmask),
        .data_o      (sh_data),
        .mask_o      (sh_mask)
    );

    // Register file writes and registered readback; STATUS is not writable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (xreg_wr_en_i && !xreg_num_i[3]) begin
                xr_q[xreg_num_i[2:0]] <= xreg_data_i;
            end
            if (xreg_num_i == XR_BLITR_STATUS) begin
                rdata_q <= {busy, queued_q, {(DATA_W-2){1'b0}}};
            end else if (!xreg_num_i[3]) begin
                rdata_q <= xr_q[xreg_num_i[2:0]];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BR_IDLE;
            queued_q <= 1'b0;
            cfg_q    <= '0;
            ptr_q    <= '0;
            bus_q    <= '{sel: 1'b0, wr: 1'b0, addr: '0, data: '0, mask: '1};
        end else begin
            state_q  <= state_d;
            queued_q <= queued_d;
            cfg_q    <= cfg_d;
            ptr_q    <= ptr_d;
            bus_q    <= bus_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        queued_d = queued_q;
        cfg_d    = cfg_q;
        ptr_d    = ptr_q;
        bus_d    = bus_q;

        case (state_q)
            BR_IDLE: begin
                if (queued_q) state_d = BR_SETUP;
            end
            BR_SETUP: begin
                cfg_d.fill     = r_mode[BLITR_MODE_FILL_BIT];
                cfg_d.shift    = r_mode[BLITR_MODE_SHIFT_LSB +: BLITR_MODE_SHIFT_W];
                cfg_d.rd_mod   = r_rd_mod[ADDR_W-1:0];
                cfg_d.wr_mod   = r_wr_mod[ADDR_W-1:0];
                cfg_d.fmask    = r_mask[DATA_W-1 -: NIB_W];
                cfg_d.lmask    = r_mask[DATA_W-1-NIB_W -: NIB_W];
                cfg_d.width    = r_width[CNT_W-1:0];
                cfg_d.fill_val = r_rd_addr;
                ptr_d.rd_addr  = r_rd_addr[ADDR_W-1:0];
                ptr_d.wr_addr  = r_wr_addr[ADDR_W-1:0];
                ptr_d.col      = r_width[CNT_W-1:0];
                ptr_d.row      = r_height[CNT_W-1:0];
                ptr_d.carry    = '0;
                queued_d       = 1'b0;
                state_d        = r_mode[BLITR_MODE_FILL_BIT] ? BR_WRITE : BR_READ;
            end
            BR_READ: begin
                bus_d.sel     = 1'b1;
                bus_d.wr      = 1'b0;
                bus_d.addr    = ptr_q.rd_addr;
                ptr_d.rd_addr = ptr_q.rd_addr + ADDR_W'(1);
                state_d       = BR_WAIT_READ;
            end
            BR_WAIT_READ: begin
                if (blit_vram_ack_i) begin
                    bus_d.sel  = 1'b0;
                    ptr_d.word = blit_vram_data_i;
                    state_d    = BR_WRITE;
                end
            end
            BR_WRITE: begin
                bus_d.sel     = 1'b1;
                bus_d.wr      = 1'b1;
                bus_d.addr    = ptr_q.wr_addr;
                bus_d.data    = sh_data;
                bus_d.mask    = sh_mask;
                ptr_d.wr_addr = ptr_q.wr_addr + ADDR_W'(1);
                state_d       = BR_WAIT_WRITE;
            end
            BR_WAIT_WRITE: begin
                if (blit_vram_ack_i) begin
                    bus_d.sel   = 1'b0;
                    ptr_d.carry = cur;
                    if (ptr_q.col != '0) begin
                        ptr_d.col = ptr_q.col - CNT_W'(1);
                        state_d   = cfg_q.fill ? BR_WRITE : BR_READ;
                    end else begin
                        state_d   = BR_LINE_END;
                    end
                end
            end
            BR_LINE_END: begin
                // Modulos are two's complement, so a plain wrapping add covers negative steps.
                ptr_d.rd_addr = ptr_q.rd_addr + cfg_q.rd_mod;
                ptr_d.wr_addr = ptr_q.wr_addr + cfg_q.wr_mod;
                ptr_d.carry   = '0;
                if (ptr_q.row != '0) begin
                    ptr_d.row = ptr_q.row - CNT_W'(1);
                    ptr_d.col = cfg_q.width;
                    state_d   = cfg_q.fill ? BR_WRITE : BR_READ;
                end else begin
                    state_d   = BR_DONE;
                end
            end
            BR_DONE: begin
                state_d = queued_q ? BR_SETUP : BR_IDLE;
            end
            default: begin
                state_d = BR_IDLE;
            end
        endcase

        // A HEIGHT write landing on the SETUP cycle stays queued for the next rectangle.
        if (height_wr) queued_d = 1'b1;
    end

    assign xreg_data_o      = rdata_q;
    assign blit_busy_o      = busy;
    assign blit_done_intr_o = (state_q == BR_DONE);
    assign blit_vram_sel_o  = bus_q.sel;
    assign blit_wr_o        = bus_q.wr;
    assign blit_wr_mask_o   = bus_q.mask;
    assign blit_addr_o      = bus_q.addr;
    assign blit_data_o      = bus_q.data;

endmodule

// File: tb/tb_blit_rect.sv
// Scoreboard bench for blit_rect: expected VRAM accesses are queued when a
// rectangle is programmed and checked as the VRAM responder services them.
module tb_blit_rect;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        xwe;
    logic [3:0]  xnum;
    logic [15:0] xdin, xdout;
    logic        busy, intr, sel, ack, wr;
    logic [3:0]  wmask;
    logic [15:0] addr, vdata, wdata;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
    } acc_t;

    acc_t        exp_q[$];
    int          errs   = 0;
    int          checks = 0;
    logic [15:0] rg[8];
    logic [15:0] mem[int];
    bit          hold_ack = 1'b0;

    blit_rect dut (
        .clk             (clk),
        .reset_n_i       (reset_n),
        .xreg_wr_en_i    (xwe),
        .xreg_num_i      (xnum),
        .xreg_data_i     (xdin),
        .xreg_data_o     (xdout),
        .blit_busy_o     (busy),
        .blit_done_intr_o(intr),
        .blit_vram_sel_o (sel),
        .blit_vram_ack_i (ack),
        .blit_wr_o       (wr),
        .blit_wr_mask_o  (wmask),
        .blit_addr_o     (addr),
        .blit_vram_data_i(vdata),
        .blit_data_o     (wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit w, input logic [15:0] a, input logic [15:0] d, input logic [3:0] m);
        acc_t e;
        e.wr = w; e.addr = a; e.data = d; e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic wreg(input logic [3:0] n, input logic [15:0] d);
        @(negedge clk);
        xnum = n; xdin = d; xwe = 1'b1;
        if (n < 4'd8) rg[n[2:0]] = d;
        @(negedge clk);
        xwe = 1'b0;
    endtask

    task automatic rreg(input logic [3:0] n, output logic [15:0] d);
        @(negedge clk);
        xnum = n; xwe = 1'b0;
        @(negedge clk);
        d = xdout;
    endtask

    // Reference walk of the rectangle from the shadow register values.
    task automatic model();
        logic [15:0] ra, wa, carry, cur;
        logic [31:0] cat;
        logic [3:0]  m;
        bit          fill;
        int          sh;
        fill = rg[0][15];
        sh   = int'(rg[0][3:0]);
        ra   = rg[5];
        wa   = rg[6];
        for (int r = 0; r <= int'(rg[7]); r++) begin
            carry = 16'h0;
            for (int c = 0; c <= int'(rg[4]); c++) begin
                if (fill) begin
                    cur = rg[5];
                end else begin
                    push(1'b0, ra, 16'h0, 4'h0);
                    cur = mem[int'(ra)];
                    ra  = ra + 16'd1;
                end
                cat = {carry, cur} >> (4 * sh);
                m = 4'hF;
                if (c == 0) m = m & rg[3][15:12];
                if (c == int'(rg[4])) m = m & rg[3][11:8];
                push(1'b1, wa, cat[15:0], m);
                wa    = wa + 16'd1;
                carry = cur;
            end
            ra = ra + rg[1];
            wa = wa + rg[2];
        end
    endtask

    task automatic wait_intr(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (intr) seen++;
        end
        chk("intr_cnt", seen, n);
        @(negedge clk);
        chk("busy_fall", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    // VRAM responder: 0..2 wait cycles per request, checks each access.
    initial begin
        int   wc;
        bit   psel;
        acc_t e;
        ack = 1'b0; vdata = 16'h0; wc = 0; psel = 1'b0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (sel && !psel) wc = $urandom_range(0, 2);
            psel = sel;
            if (sel && !hold_ack) begin
                if (wc == 0) begin
                    ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexp_acc", {15'h0, wr, addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc_kind", wr, e.wr);
                        chk("acc_addr", addr, e.addr);
                        if (e.wr) begin
                            chk("wr_data", wdata, e.data);
                            chk("wr_mask", wmask, e.mask);
                        end else begin
                            vdata = mem[int'(addr)];
                        end
                    end
                end else begin
                    wc--;
                end
            end
        end
    end

    initial begin
        logic [15:0] rd;
        int          nsel, nint;
        bit          found;
        reset_n = 1'b0; xwe = 1'b0; xnum = 4'h0; xdin = 16'h0;
        for (int i = 0; i < 8; i++) rg[i] = 16'h0;
        for (int i = 0; i < 64; i++) mem[32'h1000 + i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[32'h1000 + i] = 16'hA001 + 16'(i);
        mem[32'h1100] = 16'h1234;
        mem[32'h1101] = 16'h5678;

        repeat (3) @(negedge clk);
        chk("rst_sel", sel, 1'b0);
        chk("rst_wr", wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_intr", intr, 1'b0);
        chk("rst_mask", wmask, 4'hF);
        chk("rst_addr", addr, 16'h0);
        chk("rst_data", wdata, 16'h0);
        chk("rst_xdata", xdout, 16'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // linear copy
        wreg(4'h3, 16'hFF00);
        wreg(4'h4, 16'd3);
        wreg(4'h5, 16'h1000);
        wreg(4'h6, 16'h2000);
        wreg(4'h7, 16'd0);
        model();
        wait_intr(1);
        rreg(4'h4, rd);
        chk("rb_width", rd, 16'd3);
        rreg(4'h9, rd);
        chk("rb_unused", rd, 16'h0);

        // 2-D copy with negative write modulo
        wreg(4'h1, 16'd6);
        wreg(4'h2, 16'hFFFE);
        wreg(4'h4, 16'd1);
        wreg(4'h7, 16'd2);
        model();
        wait_intr(1);

        // shift and edge masks, expectations worked by hand
        wreg(4'h0, 16'h0001);
        wreg(4'h1, 16'h0);
        wreg(4'h2, 16'h0);
        wreg(4'h3, 16'h7E00);
        wreg(4'h5, 16'h1100);
        wreg(4'h6, 16'h2100);
        push(1'b0, 16'h1100, 16'h0, 4'h0);
        push(1'b1, 16'h2100, 16'h0123, 4'h7);
        push(1'b0, 16'h1101, 16'h0, 4'h0);
        push(1'b1, 16'h2101, 16'h4567, 4'hE);
        wreg(4'h7, 16'd0);
        wait_intr(1);

        // constant fill, single-word lines
        wreg(4'h0, 16'h8000);
        wreg(4'h5, 16'hBEEF);
        wreg(4'h4, 16'd0);
        wreg(4'h2, 16'd39);
        wreg(4'h6, 16'h0000);
        wreg(4'h7, 16'd3);
        model();
        wait_intr(1);

        // queued second rectangle picks up the reprogrammed WR_ADDR
        wreg(4'h0, 16'h0);
        wreg(4'h2, 16'h0);
        wreg(4'h3, 16'hFF00);
        wreg(4'h4, 16'd3);
        wreg(4'h5, 16'h1000);
        wreg(4'h6, 16'h3000);
        wreg(4'h7, 16'd0);
        model();
        repeat (3) @(negedge clk);
        wreg(4'h7, 16'd0);
        wreg(4'h6, 16'h4000);
        model();
        rreg(4'hF, rd);
        chk("status_q", rd, 16'hC000);
        wait_intr(2);

        // reset mid-write aborts with no interrupt
        hold_ack = 1'b1;
        wreg(4'h0, 16'h8000);
        wreg(4'h5, 16'h1234);
        wreg(4'h4, 16'd7);
        wreg(4'h7, 16'd0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (sel && wr) found = 1'b1;
        end
        chk("reach_wwait", found, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_sel", sel, 1'b0);
        chk("arst_wr", wr, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_intr", intr, 1'b0);
        chk("arst_mask", wmask, 4'hF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        hold_ack = 1'b0;
        nsel = 0; nint = 0;
        repeat (40) begin
            @(negedge clk);
            if (sel) nsel++;
            if (intr) nint++;
        end
        chk("post_rst_sel", nsel, 0);
        chk("post_rst_intr", nint, 0);
        rreg(4'h4, rd);
        chk("post_rst_width", rd, 16'h0);
        chk("post_rst_sb", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
